load_aligner_unit: RTL and testbench
====================================

LOAD_ALIGNER_UNIT -- requirements
Module: load_aligner_unit

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  input  1  MEM-stage load request.
REQ-004 SHALL have ports: req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-005 SHALL have ports: req_addr  input  32  byte address of load.
REQ-006 SHALL have ports: req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-007 SHALL have ports: stall  output  1  pipeline hold; equals !req_ready || (req_valid && req_ready).
REQ-008 SHALL have ports: dmem_read  output  1  data-memory read strobe.
REQ-009 SHALL have ports: dmem_address  output  32  word-aligned read address, bits [1:0] always 00.
REQ-010 SHALL have ports: dmem_rdata  input  32  read data, valid when dmem_resp=1.
REQ-011 SHALL have ports: dmem_resp  input  1  one-cycle read-complete pulse.
REQ-012 SHALL have ports: load_valid  output  1  one-cycle pulse: load_data final.
REQ-013 SHALL have ports: load_data  output  32  aligned, extended result; held until next load_valid.
REQ-014 SHALL have ports: load_fault  output  1  qualified by load_valid; misaligned (macro off) or illegal funct3.

Function
REQ-015 SHALL implement states IDLE, READ0, READ1, RESP; registered state, registered outputs.
REQ-016 On accept in IDLE SHALL latch funct3, addr; go READ0 if legal and not faulting, else RESP with load_data=0, load_fault=1, no memory access.
REQ-017 In READ0/READ1 SHALL hold dmem_read=1 and dmem_address stable until dmem_resp; zero dmem_resp-free cycles allowed indefinitely.
REQ-018 READ0 SHALL address {addr[31:2],2'b00}; READ1 SHALL address that value + 4, wrapping mod 2^32.
REQ-019 Byte loads SHALL select byte lane addr[1:0]; LB sign-extends bit 7, LBU zero-extends.
REQ-020 Half loads SHALL select bytes addr[1:0] and addr[1:0]+1 (little-endian); LH sign-extends bit 15, LHU zero-extends.
REQ-021 LW SHALL return 4 bytes starting at addr[1:0], little-endian.
REQ-022 A load spans words when addr[1:0]+size>4 (half at offset 3, word at offsets 1-3).
REQ-023 On dmem_resp in READ0: non-spanning -> RESP; spanning (macro on) -> capture dmem_rdata to low buffer, go READ1.
REQ-024 On dmem_resp in READ1 SHALL merge buffered upper bytes of word 0 with lower bytes of word 1, go RESP.
REQ-025 RESP SHALL assert load_valid for exactly one cycle, then IDLE; req_ready returns high the following cycle.
REQ-026 Latency: accept at cycle N, dmem_resp at cycle M -> load_valid at M+1 (single access) or after second dmem_resp +1 (spanning).
REQ-027 dmem_resp in IDLE or RESP SHALL be ignored.
REQ-028 Illegal funct3 (011, 110, 111) SHALL fault regardless of address.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, dmem_read=0, dmem_address=0, load_valid=0, load_data=0, load_fault=0, buffer=0.
REQ-030 Reset mid-access SHALL abandon the request; no load_valid for it; req_ready=1 first cycle after reset deasserts.

Configuration
REQ-031 Macro LOAD_MISALIGNED_SPLIT_EN defined: spanning loads SHALL be serviced by two reads (READ1 used), load_fault=0.
REQ-032 Macro undefined: READ1 SHALL be absent; LH/LHU with addr[0]=1 and LW with addr[1:0]!=0 SHALL fault per REQ-016; half at offset 1 also faults.

Verification
REQ-033 LB addr 0x1003, mem[0x1000]=0x80FF_1234 -> one read at 0x1000, load_data=0xFFFF_FF80, load_fault=0.
REQ-034 LHU addr 0x2002, mem[0x2000]=0xBEEF_0000, resp delayed 5 cycles -> dmem_read held 5 cycles, load_data=0x0000_BEEF.
REQ-035 LW addr 0x3001, mem[0x3000]=0x4433_2211, mem[0x3004]=0x8877_6655 -> macro on: reads 0x3000 then 0x3004, load_data=0x5544_3322; macro off: no read, load_data=0, load_fault=1.
REQ-036 funct3=011 -> no dmem_read, load_valid pulse with load_fault=1, load_data=0.
REQ-037 rst asserted while in READ0 then dmem_resp arrives -> no load_valid, dmem_read=0, req_ready=1.
REQ-038 LW addr 0xFFFF_FFFE (macro on) -> second read at 0x0000_0000 (wrap), merged result correct.

Source files
------------

// File: rtl/load_aligner_unit.sv
// Load aligner: fetches the word(s) holding a RISC-V load, then extracts and extends the result.
// Define LOAD_MISALIGNED_SPLIT_EN to service word-spanning loads with two reads instead of faulting.

module load_aligner_lane #(
  parameter int LANE = 0
) (
  input  logic [7:0][7:0] win,
  input  logic [1:0]      off,
  output logic [7:0]      byte_o
);
  logic [2:0] idx;
  assign idx    = 3'(off) + 3'(LANE);
  assign byte_o = win[idx];
endmodule

module load_aligner_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        stall,
  output logic        dmem_read,
  output logic [31:0] dmem_address,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        load_fault
);

`ifdef LOAD_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ0 = 2'd1, READ1 = 2'd2, RESP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ0 = 2'd1, RESP = 2'd3} state_e;
`endif

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        dmem_read_q, dmem_read_d;
  logic [31:0] dmem_address_q, dmem_address_d;
  logic        load_valid_q, load_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_fault_q, load_fault_d;

  logic        legal_req, fault_req;
  logic [7:0][7:0] win;
  logic [3:0][7:0] raw;
  logic [31:0] ext;

  always_comb begin
    legal_req = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_req = 1'b1;
      default:                                 legal_req = 1'b0;
    endcase
  end

`ifdef LOAD_MISALIGNED_SPLIT_EN
  logic [31:0] buf_q, buf_d;
  logic        spans;
  // Half at offset 3 or word at any nonzero offset crosses into the next word.
  assign spans = (f3_q[1:0] == 2'b01 && off_q == 2'd3) ||
                 (f3_q[1:0] == 2'b10 && off_q != 2'd0);
  assign fault_req = !legal_req;
  assign win = (state_q == READ1) ? {dmem_rdata, buf_q} : {32'h0, dmem_rdata};
`else
  assign fault_req = !legal_req ||
                     (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'd0);
  assign win = {32'h0, dmem_rdata};
`endif

  for (genvar i = 0; i < 4; i++) begin : g_lane
    load_aligner_lane #(.LANE(i)) u_lane (
      .win    (win),
      .off    (off_q),
      .byte_o (raw[i])
    );
  end

  always_comb begin
    ext = 32'h0;
    case (f3_q)
      3'b000:  ext = {{24{raw[0][7]}}, raw[0]};
      3'b100:  ext = {24'h0, raw[0]};
      3'b001:  ext = {{16{raw[1][7]}}, raw[1], raw[0]};
      3'b101:  ext = {16'h0, raw[1], raw[0]};
      3'b010:  ext = raw;
      default: ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    f3_d           = f3_q;
    off_d          = off_q;
    dmem_read_d    = dmem_read_q;
    dmem_address_d = dmem_address_q;
    load_valid_d   = 1'b0;
    load_data_d    = load_data_q;
    load_fault_d   = load_fault_q;
`ifdef LOAD_MISALIGNED_SPLIT_EN
    buf_d          = buf_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (fault_req) begin
            state_d      = RESP;
            load_valid_d = 1'b1;
            load_data_d  = 32'h0;
            load_fault_d = 1'b1;
          end else begin
            state_d        = READ0;
            dmem_read_d    = 1'b1;
            dmem_address_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      READ0: begin
        if (dmem_resp) begin
`ifdef LOAD_MISALIGNED_SPLIT_EN
          if (spans) begin
            // Keep the read strobe up and move on to the following word.
            state_d        = READ1;
            buf_d          = dmem_rdata;
            dmem_address_d = dmem_address_q + 32'd4;
          end else begin
            state_d      = RESP;
            dmem_read_d  = 1'b0;
            load_valid_d = 1'b1;
            load_data_d  = ext;
            load_fault_d = 1'b0;
          end
`else
          state_d      = RESP;
          dmem_read_d  = 1'b0;
          load_valid_d = 1'b1;
          load_data_d  = ext;
          load_fault_d = 1'b0;
`endif
        end
      end
`ifdef LOAD_MISALIGNED_SPLIT_EN
      READ1: begin
        if (dmem_resp) begin
          state_d      = RESP;
          dmem_read_d  = 1'b0;
          load_valid_d = 1'b1;
          load_data_d  = ext;
          load_fault_d = 1'b0;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      f3_q           <= 3'h0;
      off_q          <= 2'h0;
      dmem_read_q    <= 1'b0;
      dmem_address_q <= 32'h0;
      load_valid_q   <= 1'b0;
      load_data_q    <= 32'h0;
      load_fault_q   <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
      buf_q          <= 32'h0;
`endif
    end else begin
      state_q        <= state_d;
      f3_q           <= f3_d;
      off_q          <= off_d;
      dmem_read_q    <= dmem_read_d;
      dmem_address_q <= dmem_address_d;
      load_valid_q   <= load_valid_d;
      load_data_q    <= load_data_d;
      load_fault_q   <= load_fault_d;
`ifdef LOAD_MISALIGNED_SPLIT_EN
      buf_q          <= buf_d;
`endif
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign stall        = !req_ready || (req_valid && req_ready);
  assign dmem_read    = dmem_read_q;
  assign dmem_address = dmem_address_q;
  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign load_fault   = load_fault_q;

endmodule

// File: tb/tb_load_aligner_unit.sv
// Directed bench for load_aligner_unit; expectations follow LOAD_MISALIGNED_SPLIT_EN when defined.
module tb_load_aligner_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic        req_ready, stall, dmem_read, dmem_resp, load_valid, load_fault;
  logic [31:0] dmem_address, dmem_rdata, load_data;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  load_aligner_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_ready(req_ready), .stall(stall),
    .dmem_read(dmem_read), .dmem_address(dmem_address), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .load_valid(load_valid), .load_data(load_data),
    .load_fault(load_fault)
  );

  // One load: nrd reads expected at a0 then a1, each answered after dly idle cycles.
  task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                         input int nrd, input logic [31:0] a0, input logic [31:0] w0,
                         input logic [31:0] a1, input logic [31:0] w1, input int dly,
                         input logic [31:0] exp_data, input logic exp_fault);
    logic [31:0] ea;
    logic [31:0] wd;
    int waited;
    @(negedge clk);
    cmp_n++; if (req_ready !== 1'b1) begin err_n++; $display("FAIL %s ready: got %b want 1", nm, req_ready); end
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr;
    #1;
    cmp_n++; if (stall !== 1'b1) begin err_n++; $display("FAIL %s stall_accept: got %b want 1", nm, stall); end
    @(negedge clk);
    req_valid = 1'b0;
    for (int r = 0; r < nrd; r++) begin
      ea = (r == 0) ? a0 : a1;
      wd = (r == 0) ? w0 : w1;
      waited = 0;
      while (dmem_read !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      cmp_n++;
      if (dmem_read !== 1'b1) begin err_n++; $display("FAIL %s read%0d_timeout: got %b want 1", nm, r, dmem_read); return; end
      for (int d = 0; d < dly; d++) begin
        cmp_n++;
        if (dmem_read !== 1'b1 || dmem_address !== ea || stall !== 1'b1) begin
          err_n++; $display("FAIL %s hold%0d_%0d: read=%b addr=%h stall=%b want 1/%h/1", nm, r, d, dmem_read, dmem_address, stall, ea);
        end
        @(negedge clk);
      end
      cmp_n++; if (dmem_address !== ea) begin err_n++; $display("FAIL %s addr%0d: got %h want %h", nm, r, dmem_address, ea); end
      dmem_resp = 1'b1; dmem_rdata = wd;
      @(negedge clk);
      dmem_resp = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    end
    cmp_n++; if (nrd == 0 && dmem_read !== 1'b0) begin err_n++; $display("FAIL %s no_read: got %b want 0", nm, dmem_read); end
    cmp_n++;
    if (load_valid !== 1'b1 || load_data !== exp_data || load_fault !== exp_fault) begin
      err_n++; $display("FAIL %s result: valid=%b data=%h fault=%b want 1/%h/%b", nm, load_valid, load_data, load_fault, exp_data, exp_fault);
    end
    @(negedge clk);
    cmp_n++;
    if (load_valid !== 1'b0 || req_ready !== 1'b1 || load_data !== exp_data || dmem_read !== 1'b0) begin
      err_n++; $display("FAIL %s after: valid=%b ready=%b data=%h read=%b want 0/1/%h/0", nm, load_valid, req_ready, load_data, dmem_read, exp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    cmp_n++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || dmem_read !== 1'b0 || dmem_address !== 32'h0 ||
        load_valid !== 1'b0 || load_data !== 32'h0 || load_fault !== 1'b0) begin
      err_n++; $display("FAIL reset: ready=%b stall=%b read=%b addr=%h valid=%b data=%h fault=%b want 1/0/0/0/0/0/0",
                        req_ready, stall, dmem_read, dmem_address, load_valid, load_data, load_fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_loads();
    do_load("lb_3",  3'b000, 32'h1003, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'hFFFF_FF80, 1'b0);
    do_load("lbu_3", 3'b100, 32'h1003, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 2, 32'h0000_0080, 1'b0);
    do_load("lb_1",  3'b000, 32'h1001, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'h0000_0012, 1'b0);
  endtask

  task automatic test_half_loads();
    do_load("lhu_delay5", 3'b101, 32'h2002, 1, 32'h2000, 32'hBEEF_0000, 32'h0, 32'h0, 5, 32'h0000_BEEF, 1'b0);
    do_load("lh_0", 3'b001, 32'h1000, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 1, 32'h0000_1234, 1'b0);
    do_load("lh_2", 3'b001, 32'h1002, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'hFFFF_80FF, 1'b0);
`ifdef LOAD_MISALIGNED_SPLIT_EN
    do_load("lhu_1", 3'b101, 32'h1001, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'h0000_FF12, 1'b0);
    do_load("lh_3span", 3'b001, 32'h3003, 2, 32'h3000, 32'h4433_2211, 32'h3004, 32'h8877_6655, 1, 32'h0000_5544, 1'b0);
`else
    do_load("lhu_1", 3'b101, 32'h1001, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
    do_load("lh_3", 3'b001, 32'h3003, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
`endif
  endtask

  task automatic test_word_loads();
    do_load("lw_0", 3'b010, 32'h1000, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'h80FF_1234, 1'b0);
`ifdef LOAD_MISALIGNED_SPLIT_EN
    do_load("lw_1span", 3'b010, 32'h3001, 2, 32'h3000, 32'h4433_2211, 32'h3004, 32'h8877_6655, 2, 32'h5544_3322, 1'b0);
    do_load("lw_wrap", 3'b010, 32'hFFFF_FFFE, 2, 32'hFFFF_FFFC, 32'hDDCC_BBAA, 32'h0000_0000, 32'h1122_3344, 0, 32'h3344_DDCC, 1'b0);
`else
    do_load("lw_1", 3'b010, 32'h3001, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
    do_load("lw_wrap", 3'b010, 32'hFFFF_FFFE, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
`endif
  endtask

  task automatic test_illegal();
    do_load("f3_011", 3'b011, 32'h1000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
    do_load("f3_110", 3'b110, 32'h1000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
    do_load("f3_111", 3'b111, 32'h1002, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0;
    cmp_n++; if (dmem_read !== 1'b1) begin err_n++; $display("FAIL rstmid_read: got %b want 1", dmem_read); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp_n++;
    if (req_ready !== 1'b1 || dmem_read !== 1'b0 || dmem_address !== 32'h0 || load_data !== 32'h0) begin
      err_n++; $display("FAIL rstmid_state: ready=%b read=%b addr=%h data=%h want 1/0/0/0", req_ready, dmem_read, dmem_address, load_data);
    end
    dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp_n++;
      if (load_valid !== 1'b0 || dmem_read !== 1'b0 || req_ready !== 1'b1) begin
        err_n++; $display("FAIL rstmid_late%0d: valid=%b read=%b ready=%b want 0/0/1", i, load_valid, dmem_read, req_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_resp_ignored();
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_resp = 1'b0;
    @(negedge clk);
    cmp_n++;
    if (load_valid !== 1'b0 || dmem_read !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
      err_n++; $display("FAIL idle_resp: valid=%b read=%b ready=%b stall=%b want 0/0/1/0", load_valid, dmem_read, req_ready, stall);
    end
  endtask

  task automatic test_back_to_back();
    do_load("b2b_a", 3'b100, 32'h4000, 1, 32'h4000, 32'h0000_00F0, 32'h0, 32'h0, 0, 32'h0000_00F0, 1'b0);
    do_load("b2b_b", 3'b011, 32'h4000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
    do_load("b2b_c", 3'b000, 32'h4000, 1, 32'h4000, 32'h0000_00F0, 32'h0, 32'h0, 0, 32'hFFFF_FFF0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_word_loads();
    test_illegal();
    test_reset_mid();
    test_resp_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
